// File: rtl/conv_pkg.sv
// Shared helpers and default widths for the convolution blocks.
// Holds the accumulator-width and signed-saturate functions plus the FSM state type.
package conv_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WGT_W  = 8;
  localparam int unsigned DEF_OUT_W  = 10;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } conv_state_t;

  // Wide enough that a full KxK x IN_CH sum of products plus bias can never overflow.
  function automatic int unsigned acc_width(input int unsigned k,
                                            input int unsigned in_ch,
                                            input int unsigned data_w,
                                            input int unsigned wgt_w);
    return data_w + wgt_w + int'($clog2(k * k * in_ch)) + 1;
  endfunction

  function automatic int unsigned ch_width(input int unsigned in_ch);
    return (in_ch > 1) ? int'($clog2(in_ch)) : 1;
  endfunction

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] x,
                                               input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv_kxk_accum_if.sv
// Patch/kernel input beat and saturated pixel output handshake for conv_kxk_accum.
interface conv_kxk_accum_if
  import conv_pkg::*;
#(
  parameter int unsigned K      = 3,
  parameter int unsigned IN_CH  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WGT_W  = DEF_WGT_W,
  parameter int unsigned BIAS_W = 8,
  parameter int unsigned OUT_W  = DEF_OUT_W
);
  localparam int unsigned CH_W = ch_width(IN_CH);

  logic                       in_valid;
  logic                       in_ready;
  logic [K*K*DATA_W-1:0]      in_patch;
  logic [K*K*WGT_W-1:0]       in_kernel;
  logic signed [BIAS_W-1:0]   bias;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_W-1:0]    out_pixel;
  logic [CH_W-1:0]            ch_idx;

  modport master (
    output in_valid, in_patch, in_kernel, bias, out_ready,
    input  in_ready, out_valid, out_pixel, ch_idx
  );

  modport slave (
    input  in_valid, in_patch, in_kernel, bias, out_ready,
    output in_ready, out_valid, out_pixel, ch_idx
  );

endinterface

// File: rtl/conv_dot_kxk.sv
// Combinational KxK signed dot product: K*K multipliers feeding one reduction.
module conv_dot_kxk #(
  parameter int unsigned K      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WGT_W  = 8,
  parameter int unsigned DOT_W  = DATA_W + WGT_W + 5
) (
  input  logic [K*K*DATA_W-1:0]  patch,
  input  logic [K*K*WGT_W-1:0]   kernel,
  output logic signed [DOT_W-1:0] dot
);
  localparam int unsigned TAPS = K * K;

  logic signed [DOT_W-1:0] prod [TAPS];

  // Operands are sign-extended to DOT_W first so each product is exact.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod[i] = DOT_W'($signed(patch[i*DATA_W +: DATA_W])) *
                DOT_W'($signed(kernel[i*WGT_W +: WGT_W]));
    end
  end

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    logic signed [DOT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum = sum + prod[i];
    end
    dot = sum;
  end

endmodule

// File: rtl/conv_kxk_accum.sv
// One output pixel of a KxK, IN_CH-channel convolution: accumulate, add bias, saturate.
// Optional fused ReLU when CONV_KXK_RELU_EN is defined.
module conv_kxk_accum
  import conv_pkg::*;
#(
  parameter int unsigned K      = 3,
  parameter int unsigned IN_CH  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WGT_W  = DEF_WGT_W,
  parameter int unsigned BIAS_W = 8,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input logic              clk,
  input logic              rst,
  conv_kxk_accum_if.slave  io
);
  localparam int unsigned ACC_W = acc_width(K, IN_CH, DATA_W, WGT_W);
  localparam int unsigned CH_W  = ch_width(IN_CH);

  conv_state_t             state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] dot;
  logic signed [BIAS_W-1:0] bias_c;
  logic signed [ACC_W-1:0] total_c;
  logic signed [OUT_W-1:0] sat_c;
  logic signed [OUT_W-1:0] res_c;
  logic                    last_beat_c;

  conv_dot_kxk #(
    .K      (K),
    .DATA_W (DATA_W),
    .WGT_W  (WGT_W),
    .DOT_W  (ACC_W)
  ) u_dot (
    .patch  (io.in_patch),
    .kernel (io.in_kernel),
    .dot    (dot)
  );

  assign bias_c      = io.bias;
  assign last_beat_c = (io.ch_idx == CH_W'(IN_CH - 1));
  assign total_c     = acc + dot + ACC_W'(bias_c);
  assign sat_c       = OUT_W'(sat_s(64'(total_c), OUT_W));

  // ReLU, when fused, is applied after saturation so the clamp sees the signed value.
`ifdef CONV_KXK_RELU_EN
  assign res_c = sat_c[OUT_W-1] ? '0 : sat_c;
`else
  assign res_c = sat_c;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      io.ch_idx    <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_pixel <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (io.in_valid && io.in_ready) begin
            if (last_beat_c) begin
              io.out_pixel <= res_c;
              io.out_valid <= 1'b1;
              io.in_ready  <= 1'b0;
              acc          <= '0;
              io.ch_idx    <= '0;
              state        <= HOLD;
            end else begin
              acc       <= acc + dot;
              io.ch_idx <= io.ch_idx + CH_W'(1);
            end
          end
        end
        HOLD: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            state        <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_kxk_accum.sv
// Directed bench for conv_kxk_accum with an expected-pixel queue filled as beats are accepted.
module tb_conv_kxk_accum;

  localparam int K      = 3;
  localparam int IN_CH  = 4;
  localparam int DATA_W = 8;
  localparam int WGT_W  = 8;
  localparam int BIAS_W = 8;
  localparam int OUT_W  = 10;
  localparam int TAPS   = K * K;
  localparam int OMAX   = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN   = -(1 << (OUT_W - 1));

  logic clk = 1'b0;
  logic rst;

  int     total  = 0;
  int     passed = 0;
  int     fails  = 0;
  int     exp_q[$];
  longint m_acc;
  int     m_ch;

  conv_kxk_accum_if #(
    .K(K), .IN_CH(IN_CH), .DATA_W(DATA_W), .WGT_W(WGT_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)
  ) bus ();

  conv_kxk_accum #(
    .K(K), .IN_CH(IN_CH), .DATA_W(DATA_W), .WGT_W(WGT_W), .BIAS_W(BIAS_W), .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int expect_pixel(input longint v);
    longint s;
    s = (v > OMAX) ? longint'(OMAX) : ((v < OMIN) ? longint'(OMIN) : v);
`ifdef CONV_KXK_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  // Present one beat and wait (bounded) for it to be accepted; update the model on acceptance.
  task automatic drive_beat(input int pix, input int wgt, input int b, input bit rnd);
    int     p[TAPS];
    int     w[TAPS];
    longint dot;
    int     guard;
    bit     last;
    dot   = 0;
    guard = 0;
    last  = (m_ch == IN_CH - 1);
    for (int i = 0; i < TAPS; i++) begin
      p[i] = rnd ? int'($urandom_range(255)) - 128 : pix;
      w[i] = rnd ? int'($urandom_range(255)) - 128 : wgt;
    end
    @(negedge clk);
    for (int i = 0; i < TAPS; i++) begin
      bus.in_patch[i*DATA_W +: DATA_W] = DATA_W'(p[i]);
      bus.in_kernel[i*WGT_W +: WGT_W]  = WGT_W'(w[i]);
    end
    bus.bias     = last ? BIAS_W'(b) : BIAS_W'($urandom);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      check("ch_idx_at_beat", bus.ch_idx, m_ch);
      for (int i = 0; i < TAPS; i++) dot += longint'(p[i]) * longint'(w[i]);
      m_acc += dot;
      if (last) begin
        exp_q.push_back(expect_pixel(m_acc + longint'(b)));
        m_acc = 0;
        m_ch  = 0;
      end else begin
        m_ch++;
      end
      @(posedge clk);
    end
  endtask

  // Called right after the final beat's accepting edge: check latency, value, stall, release.
  task automatic collect(input string tag, input int stall, input bit keep_valid);
    int exp_v;
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = keep_valid;
    check({tag, "_latency"}, bus.out_valid, 1);
    while (!bus.out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.out_valid || exp_q.size() == 0) begin
      check({tag, "_no_result"}, bus.out_valid, 1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_v = exp_q.pop_front();
    check(tag, bus.out_pixel, exp_v);
    check({tag, "_in_ready_low"}, bus.in_ready, 0);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_pixel"}, bus.out_pixel, exp_v);
      if (keep_valid) begin
        check({tag, "_hold_in_ready"}, bus.in_ready, 0);
        check({tag, "_hold_ch_idx"}, bus.ch_idx, 0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_released"}, bus.out_valid, 0);
    check({tag, "_ready_back"}, bus.in_ready, 1);
    check({tag, "_ch_idx_zero"}, bus.ch_idx, 0);
  endtask

  task automatic pixel(input string tag, input int pix, input int wgt, input int b);
    repeat (IN_CH) drive_beat(pix, wgt, b, 1'b0);
    collect(tag, 1, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_patch  = '0;
    bus.in_kernel = '0;
    bus.bias      = '0;
    m_acc         = 0;
    m_ch          = 0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pixel", bus.out_pixel, 0);
    check("rst_ch_idx", bus.ch_idx, 0);
    rst = 1'b0;

    // Basic sums, bias handling and both clamp directions.
    repeat (IN_CH) drive_beat(1, 1, 0, 1'b0);
    collect("ones_bias0", 2, 1'b0);
    pixel("ones_bias_m5", 1, 1, -5);
    pixel("ones_bias_127", 1, 1, 127);
    pixel("pos_clamp", 127, 127, 127);
    pixel("neg_clamp", -128, 127, 0);

    // Output stalled with a new beat waiting: nothing consumed until release.
    repeat (IN_CH) drive_beat(2, 1, 0, 1'b0);
    collect("stall", 5, 1'b1);
    pixel("after_stall", 1, 1, 0);

    // in_valid low mid-pixel, plus out_ready high while nothing is valid.
    repeat (2) drive_beat(3, -2, 10, 1'b0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("gap_ch_idx", bus.ch_idx, 2);
      check("gap_out_valid", bus.out_valid, 0);
      check("gap_in_ready", bus.in_ready, 1);
    end
    bus.out_ready = 1'b0;
    repeat (2) drive_beat(3, -2, 10, 1'b0);
    collect("gap_resume", 0, 1'b0);

    // Random taps and bias.
    repeat (3) begin
      repeat (IN_CH) drive_beat(0, 0, int'($urandom_range(255)) - 128, 1'b1);
      collect("random", 0, 1'b0);
    end

    // Reset in the middle of a pixel discards the partial sum.
    repeat (2) drive_beat(1, 1, 0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    check("midrst_ch_idx", bus.ch_idx, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst   = 1'b0;
    m_acc = 0;
    m_ch  = 0;
    pixel("after_reset", 1, 1, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/conv_kxk_accum.md
Name: conv_kxk_accum

Overview:
- Parametrised successor of the fixed 3x3 convolution unit.
- Computes one output pixel of a KxK, IN_CH-channel convolution.
- Accepts one channel's KxK patch plus matching KxK kernel per handshake beat and accumulates across IN_CH beats.
- After the last beat it adds bias, saturates to OUT_W and presents the result on a valid/ready output.
- Sits between the patch/line-buffer feeder and the activation write-back stage of the YOLO datapath.

Parameters:
- K, 3, kernel side length (K*K taps per beat).
- IN_CH, 4, input channels accumulated per output pixel (>=1).
- DATA_W, 8, signed pixel width.
- WGT_W, 8, signed kernel weight width.
- BIAS_W, 8, signed bias width.
- OUT_W, 10, signed output pixel width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  patch beat valid.
- in_ready  output  1  block can accept a beat.
- in_patch  input  K*K*DATA_W  signed pixels, tap (r,c) at index r*K+c.
- in_kernel  input  K*K*WGT_W  signed weights, same indexing.
- bias  input  BIAS_W  signed bias; sampled on the beat that completes the pixel.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_pixel  output  OUT_W  signed saturated result.
- ch_idx  output  clog2(IN_CH) (min 1)  channel index of the next beat to be accepted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_pixel=0, ch_idx=0, accumulator=0, state=ACCUM.
- ACC_W = DATA_W+WGT_W+clog2(K*K*IN_CH)+1. All internal arithmetic is signed at ACC_W, so no intermediate overflow is possible.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1.
  - Beat accepted when in_valid&&in_ready: dot = sum over K*K taps of pixel*weight.
  - If ch_idx<IN_CH-1: acc<=acc+dot and ch_idx++.
  - If ch_idx==IN_CH-1: out_pixel<=sat(acc+dot+sext(bias)); acc<=0; ch_idx<=0; out_valid<=1; go to HOLD.
- HOLD:
  - in_ready=0; out_pixel and out_valid held stable.
  - When out_ready=1: out_valid<=0, go to ACCUM.
- Latency: out_valid rises on the clock edge after the final beat is accepted. Maximum throughput is one pixel per IN_CH+1 cycles.
- sat(): clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Boundary conditions:
  - in_valid low mid-pixel: accumulator and ch_idx hold indefinitely.
  - out_ready high with out_valid low: no effect.
  - in_valid while in HOLD: ignored, not consumed.
  - IN_CH=1: every accepted beat produces a result.
  - Reset mid-pixel: partial accumulation discarded, ch_idx=0.

Optional Feature:
- Macro CONV_KXK_RELU_EN.
- Defined: negative saturated results are replaced by 0 before registering into out_pixel (ReLU fused).
- Undefined: signed saturated value is passed unchanged.
- Handshake and timing are identical in both builds.

Decomposition:
- Package conv_pkg holds:
  - acc-width function (clog2-based);
  - signed saturate function;
  - default width constants DATA_W, WGT_W, OUT_W shared with other conv blocks.
- Sub-module conv_dot_kxk: combinational, parametrised K/DATA_W/WGT_W; K*K signed multipliers plus adder tree producing dot. Reusable by depthwise variants.
- Top module holds the FSM, channel counter, accumulator, bias/saturate and output register.

Test Plan:
- Defaults, all pixels=1, all weights=1, bias=0, 4 beats back-to-back -> out_valid one cycle after 4th beat, out_pixel=36, in_ready=0 until out_ready.
- Same data, bias=-5 -> out_pixel=31; bias=127 -> 163.
- Pixels=127, weights=127, bias=127 -> out_pixel=511 (positive clamp).
- Pixels=-128, weights=127 -> without macro out_pixel=-512; with CONV_KXK_RELU_EN out_pixel=0.
- out_ready held low 5 cycles after result, in_valid held high -> out_pixel/out_valid stable, in_ready=0, no beat consumed, ch_idx=0. Releasing out_ready yields the next pixel after 4 more accepted beats.
- Assert rst after 2 beats of a pixel (pixels=1, weights=1), then feed 4 fresh beats -> out_pixel=36 (no carry-over), ch_idx sequence 0,1,2,3,0.
